// File: rtl/fir_tap_sequencer_if.sv
// rtl/fir_tap_sequencer_if.sv - sample/EQ inputs and MAC-side tap stream of the FIR tap sequencer
interface fir_tap_sequencer_if;
  logic               sample_en;
  logic [7:0]         eq_sel;
  logic               overrun_clr;
  logic signed [15:0] tap;
  logic [7:0]         tapnum;
  logic               mac_en;
  logic               mac_clr;
  logic               busy;
  logic               frame_done;
  logic               overrun;

  modport master (
    input  sample_en, eq_sel, overrun_clr,
    output tap, tapnum, mac_en, mac_clr, busy, frame_done, overrun
  );

  modport slave (
    output sample_en, eq_sel, overrun_clr,
    input  tap, tapnum, mac_en, mac_clr, busy, frame_done, overrun
  );
endinterface

// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - per-sample FIR coefficient sequencer (IDLE/RUN/DONE), registered outputs
// Optional FIR_TAP_SYMMETRIC_EN: banks store half the taps and are read mirrored around the centre.
module fir_tap_sequencer #(
  parameter int NTAPS  = 10,
  parameter int NBANKS = 4
) (
  input  logic                clk,
  input  logic                reset,
  fir_tap_sequencer_if.master bus
);

  localparam int         BW      = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam logic [7:0] LAST    = 8'(NTAPS - 1);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state;
  logic [7:0]    k;
  logic [BW-1:0] bank;
  logic [BW-1:0] sel_bank;
  logic [7:0]    k_inc;

  assign sel_bank = BW'(int'(bus.eq_sel) % NBANKS);
  assign k_inc    = k + 8'd1;

  // Maps a tap index onto the stored-table index.
  function automatic logic [7:0] fold(input logic [7:0] idx);
`ifdef FIR_TAP_SYMMETRIC_EN
    return (idx <= LAST - idx) ? idx : LAST - idx;
`else
    return idx;
`endif
  endfunction

  // Bank 0 pass-through, bank 1 moving average, higher banks alternate two band presets.
  function automatic logic [15:0] coef(input logic [BW-1:0] b, input logic [7:0] m);
    logic [15:0] c;
    c = 16'h0000;
    if (b == BW'(0)) begin
      c = (m == 8'd0) ? 16'h4000 : 16'h0000;
    end else if (b == BW'(1)) begin
      c = 16'h0CCD;
    end else if (!b[0]) begin
      case (m)
        8'd0:    c = 16'h0200;
        8'd1:    c = 16'h0600;
        8'd2:    c = 16'h0C00;
        8'd3:    c = 16'h1200;
        8'd4:    c = 16'h1600;
        8'd5:    c = 16'h1600;
        8'd6:    c = 16'h1200;
        8'd7:    c = 16'h0C00;
        8'd8:    c = 16'h0600;
        8'd9:    c = 16'h0200;
        default: c = 16'h0000;
      endcase
    end else begin
      case (m)
        8'd0:    c = 16'hFF00;
        8'd1:    c = 16'hFE80;
        8'd2:    c = 16'h0400;
        8'd3:    c = 16'hF800;
        8'd4:    c = 16'h3000;
        8'd5:    c = 16'h3000;
        8'd6:    c = 16'hF800;
        8'd7:    c = 16'h0400;
        8'd8:    c = 16'hFE80;
        8'd9:    c = 16'hFF00;
        default: c = 16'h0000;
      endcase
    end
    return c;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      k              <= 8'd0;
      bank           <= '0;
      bus.tap        <= 16'sd0;
      bus.tapnum     <= 8'd0;
      bus.mac_en     <= 1'b0;
      bus.mac_clr    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (k == LAST) begin
            state          <= ST_DONE;
            bus.tap        <= 16'sd0;
            bus.mac_en     <= 1'b0;
            bus.mac_clr    <= 1'b0;
            bus.frame_done <= 1'b1;
          end else begin
            k           <= k_inc;
            bus.tapnum  <= k_inc;
            bus.tap     <= coef(bank, fold(k_inc));
            bus.mac_clr <= 1'b0;
          end
        end
        default: begin
          // IDLE and DONE both accept a new sample, so back-to-back frames have no gap.
          if (bus.sample_en) begin
            state          <= ST_RUN;
            bank           <= sel_bank;
            k              <= 8'd0;
            bus.tapnum     <= 8'd0;
            bus.tap        <= coef(sel_bank, fold(8'd0));
            bus.mac_en     <= 1'b1;
            bus.mac_clr    <= 1'b1;
            bus.busy       <= 1'b1;
            bus.frame_done <= 1'b0;
          end else begin
            state          <= ST_IDLE;
            bus.tapnum     <= 8'd0;
            bus.tap        <= 16'sd0;
            bus.mac_en     <= 1'b0;
            bus.mac_clr    <= 1'b0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
          end
        end
      endcase

      if (state == ST_RUN && bus.sample_en) begin
        bus.overrun <= 1'b1;
      end else if (bus.overrun_clr) begin
        bus.overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb/tb_fir_tap_sequencer.sv - scoreboard bench for fir_tap_sequencer
module tb_fir_tap_sequencer;
  localparam int NTAPS = 10;

  typedef struct {
    int          cyc;
    int          tapnum;
    logic [15:0] tap;
    logic        clr;
  } tap_exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  tap_exp_t tq[$];
  int       dq[$];

  fir_tap_sequencer_if bus();

  fir_tap_sequencer #(.NTAPS(NTAPS), .NBANKS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] exp_coef(input int b, input int i);
    if (b == 1) return 16'h0CCD;
`ifdef FIR_TAP_SYMMETRIC_EN
    if (b == 0 && (i == 0 || i == NTAPS - 1)) return 16'h4000;
`else
    if (b == 0 && i == 0) return 16'h4000;
`endif
    return 16'h0000;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; the strobe is sampled on the following edge.
  task automatic start_frame(input logic [7:0] sel, input int b, input int n_obs, input bit with_done);
    int c0;
    c0 = cyc;
    bus.eq_sel    = sel;
    bus.sample_en = 1'b1;
    for (int i = 0; i < n_obs; i++) begin
      tq.push_back('{cyc: c0 + 1 + i, tapnum: i, tap: exp_coef(b, i), clr: (i == 0)});
    end
    if (with_done) dq.push_back(c0 + 1 + NTAPS);
    wait_cycles(1);
    bus.sample_en = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_tap"},        32'(bus.tap), 32'd0);
    chk({tag, "_tapnum"},     32'(bus.tapnum), 32'd0);
    chk({tag, "_mac_en"},     32'(bus.mac_en), 32'd0);
    chk({tag, "_mac_clr"},    32'(bus.mac_clr), 32'd0);
    chk({tag, "_busy"},       32'(bus.busy), 32'd0);
    chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
    chk({tag, "_overrun"},    32'(bus.overrun), 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a tap or a frame_done.
  always @(negedge clk) begin
    if (!reset) begin
      while (tq.size() > 0 && tq[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL tap_missing: tapnum %0d not seen, expected at cycle %0d", tq[0].tapnum, tq[0].cyc);
        void'(tq.pop_front());
      end
      while (dq.size() > 0 && dq[0] < cyc) begin
        checks++;
        failures++;
        $display("FAIL done_missing: frame_done not seen, expected at cycle %0d", dq[0]);
        void'(dq.pop_front());
      end
      if (bus.mac_en) begin
        if (tq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tap_unexpected: mac_en with tapnum %0d at cycle %0d", bus.tapnum, cyc);
        end else begin
          tap_exp_t e;
          e = tq.pop_front();
          chk("tap_cycle", 32'(cyc), 32'(e.cyc));
          chk("tapnum", 32'(bus.tapnum), 32'(e.tapnum));
          chk("tap", 32'(bus.tap), 32'(e.tap));
          chk("mac_clr", 32'(bus.mac_clr), 32'(e.clr));
        end
      end else begin
        chk("tap_idle", 32'(bus.tap), 32'd0);
        chk("mac_clr_idle", 32'(bus.mac_clr), 32'd0);
      end
      if (bus.frame_done) begin
        if (dq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected: frame_done at cycle %0d", cyc);
        end else begin
          chk("done_cycle", 32'(cyc), 32'(dq.pop_front()));
          chk("done_tapnum", 32'(bus.tapnum), 32'(NTAPS - 1));
        end
      end
      chk("busy", 32'(bus.busy), 32'(bus.mac_en | bus.frame_done));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    bus.sample_en   = 1'b0;
    bus.eq_sel      = 8'd0;
    bus.overrun_clr = 1'b0;
    wait_cycles(3);
    check_idle("reset");
    reset = 1'b0;
    wait_cycles(2);

    // Moving average, pass-through, and bank = eq_sel mod 4.
    start_frame(8'd1, 1, NTAPS, 1'b1);
    wait_cycles(12);
    start_frame(8'd0, 0, NTAPS, 1'b1);
    wait_cycles(12);
    start_frame(8'd5, 1, NTAPS, 1'b1);
    wait_cycles(12);
    start_frame(8'hFC, 0, NTAPS, 1'b1);
    wait_cycles(12);
    chk("overrun_quiet", 32'(bus.overrun), 32'd0);

    // Sample at tapnum 4: frame unchanged, overrun set, then cleared.
    start_frame(8'd1, 1, NTAPS, 1'b1);
    wait_cycles(4);
    bus.sample_en = 1'b1;
    wait_cycles(1);
    bus.sample_en = 1'b0;
    chk("overrun_set", 32'(bus.overrun), 32'd1);
    wait_cycles(7);
    chk("overrun_sticky", 32'(bus.overrun), 32'd1);
    bus.overrun_clr = 1'b1;
    wait_cycles(1);
    bus.overrun_clr = 1'b0;
    chk("overrun_cleared", 32'(bus.overrun), 32'd0);

    // Set beats clear in the same cycle.
    start_frame(8'd1, 1, NTAPS, 1'b1);
    wait_cycles(2);
    bus.sample_en = 1'b1;
    wait_cycles(1);
    bus.sample_en = 1'b0;
    chk("overrun_set2", 32'(bus.overrun), 32'd1);
    wait_cycles(1);
    bus.sample_en   = 1'b1;
    bus.overrun_clr = 1'b1;
    wait_cycles(1);
    bus.sample_en   = 1'b0;
    bus.overrun_clr = 1'b0;
    chk("overrun_set_priority", 32'(bus.overrun), 32'd1);
    wait_cycles(6);
    bus.overrun_clr = 1'b1;
    wait_cycles(1);
    bus.overrun_clr = 1'b0;
    chk("overrun_cleared2", 32'(bus.overrun), 32'd0);

    // Strobe while frame_done is showing: next frame starts with no idle gap.
    start_frame(8'd1, 1, NTAPS, 1'b1);
    wait_cycles(10);
    chk("b2b_in_done", 32'(bus.frame_done), 32'd1);
    start_frame(8'd0, 0, NTAPS, 1'b1);
    wait_cycles(12);
    chk("b2b_no_overrun", 32'(bus.overrun), 32'd0);

    // eq_sel change mid-frame only affects the next frame.
    start_frame(8'd1, 1, NTAPS, 1'b1);
    wait_cycles(3);
    bus.eq_sel = 8'd0;
    wait_cycles(10);
    start_frame(8'd0, 0, NTAPS, 1'b1);
    wait_cycles(12);

    // Asynchronous reset while tapnum 6 is on the bus.
    start_frame(8'd1, 1, 6, 1'b0);
    wait_cycles(6);
    chk("pre_reset_tapnum", 32'(bus.tapnum), 32'd6);
    reset = 1'b1;
    #1;
    check_idle("async_reset");
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(5);
    check_idle("post_reset_idle");
    start_frame(8'd1, 1, NTAPS, 1'b1);
    wait_cycles(12);

    chk("tap_queue_empty", 32'(tq.size()), 32'd0);
    chk("done_queue_empty", 32'(dq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
